// File: rtl/disp_pkg.sv
// Shared opcodes, status codes, AEG index map and FSM encoding for the
// dispatch initiator.
package disp_pkg;

  localparam logic [1:0] OP_WR   = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_INST = 2'd2;
  localparam logic [1:0] OP_POLL = 2'd3;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_EXC = 2'd1;
  localparam logic [1:0] ST_TMO = 2'd2;

  localparam logic [17:0] AEG_CTLQUE    = 18'd0;
  localparam logic [17:0] AEG_EXCEPTION = 18'd1;
  localparam logic [17:0] AEG_PART      = 18'd2;
  localparam logic [17:0] AEG_CONFIG    = 18'd3;
  localparam logic [17:0] AEG_POLL      = 18'd4;

  // Shared sub-step counter width (write phase, stall mask, poll gap).
  localparam int AUX_W = 8;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_WR         = 4'd1,
    S_RD         = 4'd2,
    S_RD_WAIT    = 4'd3,
    S_INST_WAIT  = 4'd4,
    S_INST       = 4'd5,
    S_STALL_WAIT = 4'd6,
    S_POLL_GAP   = 4'd7,
    S_POLL_RD    = 4'd8,
    S_POLL_WAIT  = 4'd9,
    S_RSP        = 4'd10
  } disp_state_e;

endpackage

// File: rtl/disp_tmo_cnt.sv
// Saturating wait-cycle counter; done is high once the count reaches all-ones.
module disp_tmo_cnt #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !done) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done = &cnt_q;

endmodule

// File: rtl/disp_initiator.sv
// Host-side dispatch initiator: turns one command at a time into AEG
// write/read, CAEP issue or idle polling, and returns exactly one response.
module disp_initiator
  import disp_pkg::*;
#(
  parameter int          TMO_W    = 16,
  parameter logic [17:0] POLL_IDX = AEG_POLL,
  parameter int          POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [1:0]  cmd_op,
  input  logic [17:0] cmd_idx,
  input  logic [63:0] cmd_data,
  input  logic [4:0]  cmd_inst,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [63:0] rsp_data,
  output logic [15:0] rsp_exc,
  output logic [1:0]  rsp_status,
  output logic        disp_inst_vld,
  output logic [4:0]  disp_inst,
  output logic [17:0] disp_aeg_idx,
  output logic        disp_aeg_rd,
  output logic        disp_aeg_wr,
  output logic [63:0] disp_aeg_wr_data,
  input  logic [17:0] disp_aeg_cnt,
  input  logic [15:0] disp_exception,
  input  logic [63:0] disp_rtn_data,
  input  logic        disp_rtn_data_vld,
  input  logic        disp_idle,
  input  logic        disp_stall,
  output logic [3:0]  dbg_state,
  output logic        dbg_oob
);

  disp_state_e      state_q, state_d;
  logic [AUX_W-1:0] aux_q, aux_d;
  logic             rdy_q;
  logic [17:0]      idx_q, idx_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [4:0]       inst_q, inst_d;
  logic             wr_q, wr_d, rd_q, rd_d, ivld_q, ivld_d;
  logic [63:0]      rdata_q, rdata_d;
  logic [15:0]      exc_q, exc_d;
  logic             hit_q, hit_d, hit_now;
  logic [1:0]       status_q, status_d;
  logic             tmo_clr, tmo_inc, tmo_done;

  disp_tmo_cnt #(.W(TMO_W)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (tmo_clr),
    .inc   (tmo_inc),
    .done  (tmo_done)
  );

  always_comb begin
    state_d  = state_q;
    aux_d    = aux_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    inst_d   = inst_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    ivld_d   = 1'b0;
    rdata_d  = rdata_q;
    exc_d    = exc_q;
    hit_d    = hit_q;
    status_d = status_q;
    tmo_clr  = 1'b0;
    tmo_inc  = 1'b0;
    hit_now  = hit_q | disp_exception[1];
    if (state_q != S_IDLE && state_q != S_RSP) exc_d = exc_q | disp_exception;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_vld && rdy_q) begin
          tmo_clr  = 1'b1;
          aux_d    = '0;
          rdata_d  = '0;
          exc_d    = '0;
          hit_d    = 1'b0;
          status_d = ST_OK;
          idx_d    = cmd_idx;
          wdata_d  = cmd_data;
          inst_d   = cmd_inst;
          unique case (cmd_op)
            OP_WR:   begin state_d = S_WR; wr_d = 1'b1; end
            OP_RD:   begin state_d = S_RD; rd_d = 1'b1; end
            OP_INST: state_d = S_INST_WAIT;
            default: begin state_d = S_POLL_RD; rd_d = 1'b1; idx_d = POLL_IDX; end
          endcase
        end
      end
      S_WR: begin
        // Second cycle carries the responder's verdict on the write.
        if (aux_q == '0) begin
          aux_d = aux_q + 1'b1;
        end else begin
          status_d = (|disp_exception) ? ST_EXC : ST_OK;
          state_d  = S_RSP;
        end
      end
      S_RD, S_POLL_RD: begin
        hit_d = hit_now;
        if (state_q == S_POLL_RD) tmo_inc = 1'b1;
        if (state_q == S_POLL_RD && tmo_done) begin
          status_d = ST_TMO;
          state_d  = S_RSP;
        end else begin
          state_d = (state_q == S_RD) ? S_RD_WAIT : S_POLL_WAIT;
        end
      end
      S_RD_WAIT, S_POLL_WAIT: begin
        tmo_inc = 1'b1;
        hit_d   = hit_now;
        // Data arriving on the terminal-count cycle still wins over timeout.
        if (disp_rtn_data_vld) begin
          rdata_d = disp_rtn_data;
          if (state_q == S_RD_WAIT || disp_rtn_data[0]) begin
            status_d = hit_now ? ST_EXC : ST_OK;
            state_d  = S_RSP;
          end else if (tmo_done) begin
            status_d = ST_TMO;
            state_d  = S_RSP;
          end else if (POLL_GAP == 0) begin
            rd_d    = 1'b1;
            state_d = S_POLL_RD;
          end else begin
            aux_d   = '0;
            state_d = S_POLL_GAP;
          end
        end else if (tmo_done) begin
          status_d = ST_TMO;
          state_d  = S_RSP;
        end
      end
      S_POLL_GAP: begin
        tmo_inc = 1'b1;
        if (tmo_done) begin
          status_d = ST_TMO;
          state_d  = S_RSP;
        end else if (aux_q == AUX_W'(POLL_GAP - 1)) begin
          rd_d    = 1'b1;
          state_d = S_POLL_RD;
        end else begin
          aux_d = aux_q + 1'b1;
        end
      end
      S_INST_WAIT: begin
        tmo_inc = 1'b1;
        if (tmo_done) begin
          status_d = ST_TMO;
          state_d  = S_RSP;
        end else if (!disp_stall && disp_idle) begin
          ivld_d  = 1'b1;
          state_d = S_INST;
        end
      end
      S_INST: begin
        aux_d   = '0;
        state_d = S_STALL_WAIT;
      end
      S_STALL_WAIT: begin
        tmo_inc = 1'b1;
        if (aux_q == '0 && disp_exception[0]) hit_d = 1'b1;
        // The responder's own stall from this instruction is masked briefly.
        if (tmo_done) begin
          status_d = ST_TMO;
          state_d  = S_RSP;
        end else if (aux_q < AUX_W'(2)) begin
          aux_d = aux_q + 1'b1;
        end else if (!disp_stall) begin
          status_d = hit_q ? ST_EXC : ST_OK;
          state_d  = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      aux_q    <= '0;
      rdy_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      inst_q   <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      ivld_q   <= 1'b0;
      rdata_q  <= '0;
      exc_q    <= '0;
      hit_q    <= 1'b0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      aux_q    <= aux_d;
      rdy_q    <= (state_d == S_IDLE);
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      inst_q   <= inst_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ivld_q   <= ivld_d;
      rdata_q  <= rdata_d;
      exc_q    <= exc_d;
      hit_q    <= hit_d;
      status_q <= status_d;
    end
  end

  // Handshakes: a command transfers on cmd_vld && cmd_rdy; a response is
  // held stable from rsp_vld rising until the cycle rsp_vld && rsp_rdy.
  assign cmd_rdy          = rdy_q;
  assign rsp_vld          = (state_q == S_RSP);
  assign rsp_data         = rdata_q;
  assign rsp_exc          = exc_q;
  assign rsp_status       = status_q;
  assign disp_inst_vld    = ivld_q;
  assign disp_inst        = inst_q;
  assign disp_aeg_idx     = idx_q;
  assign disp_aeg_rd      = rd_q;
  assign disp_aeg_wr      = wr_q;
  assign disp_aeg_wr_data = wdata_q;
  assign dbg_state        = state_q;
  assign dbg_oob          = (state_q != S_IDLE) && (idx_q >= disp_aeg_cnt);

endmodule

// File: tb/tb_disp_initiator.sv
// Directed bench for disp_initiator with a small behavioural responder stub;
// a second instance with a 4-bit timeout covers the stuck-stall case.
module tb_disp_initiator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cmd_vld, cmd_vld_t, rsp_rdy;
  logic [1:0]  cmd_op;
  logic [17:0] cmd_idx;
  logic [63:0] cmd_data;
  logic [4:0]  cmd_inst;

  logic        cmd_rdy, rsp_vld, d_inst_vld, d_rd, d_wr, dbg_oob;
  logic [63:0] rsp_data, d_wdata;
  logic [15:0] rsp_exc;
  logic [1:0]  rsp_status;
  logic [4:0]  d_inst;
  logic [17:0] d_idx;
  logic [3:0]  dbg_state;

  logic        cmd_rdy_t, rsp_vld_t, d_inst_vld_t, d_rd_t, d_wr_t, dbg_oob_t;
  logic [63:0] rsp_data_t, d_wdata_t;
  logic [15:0] rsp_exc_t;
  logic [1:0]  rsp_status_t;
  logic [4:0]  d_inst_t;
  logic [17:0] d_idx_t;
  logic [3:0]  dbg_state_t;

  // Responder stub for the main instance.
  logic [17:0] aeg_cnt = 18'd5;
  logic [63:0] aeg [0:7];
  logic [15:0] exc_m = '0;
  logic [63:0] rtn_data = '0;
  logic        rtn_vld_m = 1'b0, tb_vld, stall, rtn_vld;
  int          cyc = 0, busy_until, post_cnt = 0, poll_reads = 0;

  // Stuck responder for the timeout instance.
  logic        stall_t = 1'b1, idle_t = 1'b0;
  logic [15:0] zero16 = '0;
  logic [63:0] zero64 = '0;
  logic        zero1 = 1'b0;

  assign stall   = (cyc < busy_until) || (post_cnt != 0);
  assign rtn_vld = rtn_vld_m | tb_vld;

  disp_initiator dut (
    .clk(clk), .reset(reset), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_data(cmd_data), .cmd_inst(cmd_inst),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_exc(rsp_exc),
    .rsp_status(rsp_status), .disp_inst_vld(d_inst_vld), .disp_inst(d_inst),
    .disp_aeg_idx(d_idx), .disp_aeg_rd(d_rd), .disp_aeg_wr(d_wr),
    .disp_aeg_wr_data(d_wdata), .disp_aeg_cnt(aeg_cnt), .disp_exception(exc_m),
    .disp_rtn_data(rtn_data), .disp_rtn_data_vld(rtn_vld), .disp_idle(!stall),
    .disp_stall(stall), .dbg_state(dbg_state), .dbg_oob(dbg_oob)
  );

  disp_initiator #(.TMO_W(4)) dut_t (
    .clk(clk), .reset(reset), .cmd_vld(cmd_vld_t), .cmd_rdy(cmd_rdy_t),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_data(cmd_data), .cmd_inst(cmd_inst),
    .rsp_vld(rsp_vld_t), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data_t), .rsp_exc(rsp_exc_t),
    .rsp_status(rsp_status_t), .disp_inst_vld(d_inst_vld_t), .disp_inst(d_inst_t),
    .disp_aeg_idx(d_idx_t), .disp_aeg_rd(d_rd_t), .disp_aeg_wr(d_wr_t),
    .disp_aeg_wr_data(d_wdata_t), .disp_aeg_cnt(aeg_cnt), .disp_exception(zero16),
    .disp_rtn_data(zero64), .disp_rtn_data_vld(zero1), .disp_idle(idle_t),
    .disp_stall(stall_t), .dbg_state(dbg_state_t), .dbg_oob(dbg_oob_t)
  );

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rtn_vld_m <= 1'b0;
    exc_m     <= '0;
    if (d_wr) begin
      if (d_idx < aeg_cnt) aeg[d_idx[2:0]] <= d_wdata;
      else exc_m <= 16'h0002;
    end
    if (d_rd) begin
      rtn_vld_m <= 1'b1;
      if (d_idx >= aeg_cnt) begin
        rtn_data <= 64'hdeadbeefdeadbeef;
        exc_m    <= 16'h0002;
      end else if (d_idx == 18'd4) begin
        rtn_data   <= {63'd0, poll_reads >= 3};
        poll_reads <= poll_reads + 1;
      end else begin
        rtn_data <= aeg[d_idx[2:0]];
      end
    end
    if (d_inst_vld) begin
      post_cnt <= 3;
      if (d_inst == 5'd3) exc_m <= 16'h0001;
    end else if (post_cnt != 0) begin
      post_cnt <= post_cnt - 1;
    end
  end

  // Strobe monitor: pulse counts, read timestamps, exclusion violations.
  int   rd_cyc [64];
  int   rd_total = 0, inst_total = 0, inst_t_total = 0, excl_viol = 0, rsp_seen = 0;
  logic prev_any = 1'b0;
  always @(posedge clk) begin
    if (d_rd && rd_total < 64) begin
      rd_cyc[rd_total] <= cyc;
      rd_total         <= rd_total + 1;
    end
    if (d_inst_vld) inst_total <= inst_total + 1;
    if (d_inst_vld_t) inst_t_total <= inst_t_total + 1;
    if ((int'(d_rd) + int'(d_wr) + int'(d_inst_vld) > 1) ||
        (prev_any && (d_rd || d_wr || d_inst_vld)))
      excl_viol <= excl_viol + 1;
    prev_any <= d_rd || d_wr || d_inst_vld;
    if (rsp_vld) rsp_seen <= rsp_seen + 1;
  end

  int n_pass = 0, n_chk = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [1:0] op, input logic [17:0] idx,
                      input logic [63:0] data, input logic [4:0] inst);
    @(negedge clk);
    check("cmd_rdy_before_cmd", 64'(cmd_rdy), 64'd1);
    cmd_vld  = 1'b1;
    cmd_op   = op;
    cmd_idx  = idx;
    cmd_data = data;
    cmd_inst = inst;
    @(posedge clk);
    #1 cmd_vld = 1'b0;
  endtask

  // lat counts the accept cycle as 1.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_vld && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic finish_rsp(input string tag);
    logic [63:0] exp;
    exp = exp_q.pop_front();
    check({tag, "_data"}, rsp_data, exp);
    @(posedge clk);
    #1 check({tag, "_hold_vld"}, 64'(rsp_vld), 64'd1);
    check({tag, "_hold_data"}, rsp_data, exp);
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1 rsp_rdy = 1'b0;
    check({tag, "_rsp_drop"}, 64'(rsp_vld), 64'd0);
    check({tag, "_cmd_rdy_back"}, 64'(cmd_rdy), 64'd1);
  endtask

  initial begin
    int lat, base;
    reset = 1'b1; cmd_vld = 1'b0; cmd_vld_t = 1'b0; rsp_rdy = 1'b0; tb_vld = 1'b0;
    cmd_op = '0; cmd_idx = '0; cmd_data = '0; cmd_inst = '0; busy_until = 0;
    repeat (3) @(posedge clk);
    #1 check("reset_cmd_rdy", 64'(cmd_rdy), 64'd0);
    check("reset_rsp_vld", 64'(rsp_vld), 64'd0);
    check("reset_strobes", 64'({d_rd, d_wr, d_inst_vld}), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 check("post_reset_cmd_rdy", 64'(cmd_rdy), 64'd1);

    // Write then read back idx 0.
    send(2'd0, 18'd0, 64'h0009_0000_0000_1000, 5'd0);
    wait_rsp(lat);
    check("wr_latency", 64'(lat), 64'd3);
    check("wr_status", 64'(rsp_status), 64'd0);
    check("wr_exc", 64'(rsp_exc), 64'd0);
    exp_q.push_back(64'd0);
    finish_rsp("wr");

    send(2'd1, 18'd0, 64'd0, 5'd0);
    wait_rsp(lat);
    check("rd_latency", 64'(lat), 64'd3);
    check("rd_status", 64'(rsp_status), 64'd0);
    check("rd_exc", 64'(rsp_exc), 64'd0);
    exp_q.push_back(64'h0009_0000_0000_1000);
    finish_rsp("rd");

    // Out-of-range read still issued; responder flags exception bit 1.
    send(2'd1, 18'd7, 64'd0, 5'd0);
    wait_rsp(lat);
    check("oob_latency", 64'(lat), 64'd3);
    check("oob_status", 64'(rsp_status), 64'd1);
    check("oob_exc", 64'(rsp_exc), 64'h0002);
    exp_q.push_back(64'hdeadbeefdeadbeef);
    finish_rsp("oob");

    // CAEP 0 with responder busy for 20 cycles.
    base = inst_total;
    @(negedge clk) busy_until = cyc + 20;
    send(2'd2, 18'd0, 64'd0, 5'd0);
    wait_rsp(lat);
    check("caep_busy_latency_window", 64'(lat >= 20 && lat <= 30), 64'd1);
    check("caep_busy_pulses", 64'(inst_total - base), 64'd1);
    check("caep_busy_status", 64'(rsp_status), 64'd0);
    check("caep_busy_exc", 64'(rsp_exc), 64'd0);
    exp_q.push_back(64'd0);
    finish_rsp("caep_busy");

    // CAEP 3 raises exception bit 0 on the cycle after the pulse.
    base = inst_total;
    send(2'd2, 18'd0, 64'd0, 5'd3);
    wait_rsp(lat);
    check("caep3_done", 64'(rsp_vld), 64'd1);
    check("caep3_pulses", 64'(inst_total - base), 64'd1);
    check("caep3_status", 64'(rsp_status), 64'd1);
    check("caep3_exc", 64'(rsp_exc), 64'h0001);
    exp_q.push_back(64'd0);
    finish_rsp("caep3");

    // Poll: idle bit rises on the 4th read.
    base = rd_total;
    send(2'd3, 18'd0, 64'd0, 5'd0);
    wait_rsp(lat);
    check("poll_done", 64'(rsp_vld), 64'd1);
    check("poll_rd_count", 64'(rd_total - base), 64'd4);
    for (int i = 1; i < 4; i++)
      check("poll_rd_spacing", 64'(rd_cyc[base + i] - rd_cyc[base + i - 1]), 64'd6);
    check("poll_status", 64'(rsp_status), 64'd0);
    exp_q.push_back(64'd1);
    finish_rsp("poll");

    // Stuck stall on the 4-bit timeout instance.
    @(negedge clk);
    check("tmo_cmd_rdy", 64'(cmd_rdy_t), 64'd1);
    cmd_vld_t = 1'b1; cmd_op = 2'd2; cmd_inst = 5'd0;
    @(posedge clk);
    #1 cmd_vld_t = 1'b0;
    lat = 1;
    while (!rsp_vld_t && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check("tmo_latency_window", 64'(lat >= 15 && lat <= 17), 64'd1);
    check("tmo_status", 64'(rsp_status_t), 64'd2);
    check("tmo_exc", 64'(rsp_exc_t), 64'd0);
    check("tmo_no_pulse", 64'(inst_t_total), 64'd0);
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1 rsp_rdy = 1'b0;
    check("tmo_rsp_drop", 64'(rsp_vld_t), 64'd0);

    // Reset in the middle of a read.
    send(2'd1, 18'd0, 64'd0, 5'd0);
    check("mid_rd_pulse", 64'(d_rd), 64'd1);
    reset = 1'b1;
    #1 check("mid_reset_rd", 64'(d_rd), 64'd0);
    check("mid_reset_cmd_rdy", 64'(cmd_rdy), 64'd0);
    check("mid_reset_idx", 64'(d_idx), 64'd0);
    check("mid_reset_state", 64'(dbg_state), 64'd0);
    @(negedge clk) reset = 1'b0;
    base = rsp_seen;
    @(negedge clk);
    check("mid_reset_cmd_rdy_back", 64'(cmd_rdy), 64'd1);
    tb_vld = 1'b1;
    @(negedge clk) tb_vld = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_reset_no_rsp", 64'(rsp_seen - base), 64'd0);
    check("mid_reset_idle", 64'(dbg_state), 64'd0);

    check("strobe_exclusion", 64'(excl_viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/disp_initiator.md
# disp_initiator

Host-side initiator for the coprocessor dispatch interface. It drives AEG writes, AEG reads and CAEP instruction issue into the personality dispatch responder, then collects read data, exceptions and idle status. It sits between a simple command/response port (firmware bridge or test harness) and the `disp_*` signal bundle. One command is in flight at a time, and every command produces exactly one response.

## Interface
- `TMO_W`, default 16: width of the timeout counter; a timeout occurs after 2^TMO_W−1 wait cycles.
- `POLL_IDX`, default 4: AEG index of the polling register (bit 0 = idle).
- `POLL_GAP`, default 4: idle cycles between successive poll reads.
- `clk`  in  1  sole clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `cmd_vld`  in  1  command valid.
- `cmd_rdy`  out  1  command accepted when `cmd_vld && cmd_rdy`.
- `cmd_op`  in  2  command opcode: 0 = AEG write, 1 = AEG read, 2 = CAEP issue, 3 = poll until idle.
- `cmd_idx`  in  18  AEG index.
- `cmd_data`  in  64  write data.
- `cmd_inst`  in  5  CAEP number.
- `rsp_vld`  out  1  response valid.
- `rsp_rdy`  in  1  response accepted.
- `rsp_data`  out  64  read data; 0 for write and CAEP.
- `rsp_exc`  out  16  OR of `disp_exception` seen during the command.
- `rsp_status`  out  2  0 = OK, 1 = exception, 2 = timeout.
- `disp_inst_vld`, `disp_inst[4:0]`, `disp_aeg_idx[17:0]`, `disp_aeg_rd`, `disp_aeg_wr`, `disp_aeg_wr_data[63:0]`  out: dispatch request bundle, all registered.
- `disp_aeg_cnt[17:0]`, `disp_exception[15:0]`, `disp_rtn_data[63:0]`, `disp_rtn_data_vld`, `disp_idle`, `disp_stall`  in: responder outputs.

## Operation
- **States:** IDLE, WR, RD, RD_WAIT, INST_WAIT, INST, STALL_WAIT, POLL_GAP, POLL_RD, POLL_WAIT, RSP.
- **IDLE:** `cmd_rdy = 1`. On accept, latch the command and go to WR, RD, INST_WAIT or POLL_RD according to `cmd_op`.
- **WR:** assert `disp_aeg_wr` for exactly one cycle with idx and data. The next cycle samples `disp_exception`, then go to RSP.
- **RD:** pulse `disp_aeg_rd` for one cycle, then RD_WAIT. Capture `disp_rtn_data` on `disp_rtn_data_vld`, then go to RSP. Both exception cycles are OR'd into `rsp_exc`.
- **Index range:** `cmd_idx >= disp_aeg_cnt` is still issued. The responder's exception bit 1 is reported as status 1; data is passed through unchanged.
- **INST_WAIT:** wait until `disp_stall == 0 && disp_idle == 1`, then INST.
- **INST:** pulse `disp_inst_vld` with `cmd_inst` for one cycle.
- **STALL_WAIT:** ignore `disp_stall` for the first 2 cycles after the pulse, since the responder's stall is derived from the instruction itself. After that, wait for `disp_stall == 0`, then go to RSP.
- **CAEP exception:** `disp_exception` bit 0 seen on the cycle after the pulse gives status 1.
- **Poll (op 3):** read `POLL_IDX` as in RD. If returned bit 0 is 1, go to RSP with that data. Otherwise wait `POLL_GAP` cycles and read again.
- **Timeout:** the timeout counter clears on command accept and increments in every wait state (RD_WAIT, INST_WAIT, STALL_WAIT, POLL_*). At all-ones it forces RSP with status 2. Status 2 takes precedence over 1.
- **RSP:** hold `rsp_vld` and its fields stable until `rsp_rdy`, then return to IDLE. `cmd_rdy` is 0 in every state except IDLE.
- **Mutual exclusion:** `disp_aeg_rd`, `disp_aeg_wr` and `disp_inst_vld` are never asserted together and never for two consecutive cycles.

## Timing
- **Reset:** asynchronous assert forces the state to IDLE and every output to 0 (`cmd_rdy` included), regardless of clock. The first cycle after deassert has `cmd_rdy = 1`.
- **Reset mid-command:** the command is dropped and no response is produced. A `disp_rtn_data_vld` arriving after reset is ignored.
- **Write latency:** accept at T, `disp_aeg_wr` at T+1, `rsp_vld` at T+3.
- **Read latency:** `disp_aeg_rd` at T+1. The responder returns data at T+2, and `rsp_vld` follows at T+3.
- **CAEP issue:** `disp_inst_vld` is asserted no earlier than T+1 and only in a cycle after `disp_stall` was sampled low.
- **Response handshake:** `rsp_vld` with `rsp_rdy` already high completes in one cycle.
- **Read-valid coincidence:** `disp_rtn_data_vld` in the same cycle as the timeout terminal count counts as data received, with status 0.

## Structure
- **Package `disp_pkg`:**
  - opcode localparams;
  - status codes;
  - state encoding;
  - AEG index constants: 0 = ctlQue, 1 = exception, 2 = part, 3 = config, 4 = poll.
- **Sub-module `disp_tmo_cnt`:** a saturating `TMO_W`-bit counter with `clr`, `inc` and `done` ports.

## Test plan
- Write idx 0 with 0x0009_0000_0000_1000, then read idx 0 → data matches, status 0, `rsp_vld` 3 cycles after each accept.
- Read idx 7 with `disp_aeg_cnt = 5` → `rsp_exc = 0x0002`, status 1, `rsp_data = 0xdeadbeefdeadbeef`.
- CAEP 0 with the responder busy for 20 cycles → exactly one `disp_inst_vld` pulse, response about 20 cycles later, status 0.
- CAEP 3 → `rsp_exc = 0x0001`, status 1.
- Poll with idle rising after 3 reads → exactly 4 `disp_aeg_rd` pulses spaced `POLL_GAP+2` apart, and `rsp_data[0] = 1`.
- With `TMO_W = 4` and `disp_stall` stuck high → status 2 after 15 cycles. Then assert `reset` mid-read → outputs go to 0 immediately, no `rsp_vld`.
